// File: rtl/byte_demux_loader.sv
// byte_demux_loader: steers an incoming byte stream into one of two
// 16-byte block buffers (key / data). Each buffer fills MSB-first, raises
// its full flag on the 16th byte, and stays frozen until it is acked.

// One block buffer: byte counter, full flag and 16 byte lanes.
module byte_buf (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,    // accepted byte for this buffer (never while full)
  input  logic [7:0]   din,
  input  logic         ack,
  output logic [127:0] blk,
  output logic         full
);
  logic [3:0]       cnt;
  logic [15:0][7:0] lanes;

  // Byte n lands in lane 15-n (== ~n) so byte 0 sits at bits [127:120].
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      full  <= 1'b0;
      lanes <= '0;
    end else if (wr) begin
      lanes[~cnt] <= din;
      cnt         <= cnt + 4'd1;
      if (cnt == 4'hF) full <= 1'b1;
    end else if (ack && full) begin
      full <= 1'b0;
    end
  end

  assign blk = lanes;
endmodule

module byte_demux_loader (
  input  logic         clk,
  input  logic         rst,
  input  logic         s1,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         key_ack,
  input  logic         data_ack,
  output logic [127:0] key_out,
  output logic [127:0] data_out,
  output logic         key_full,
  output logic         data_full
);
  localparam int NUM_BUF = 2;  // index 1 = key, index 0 = data

  logic [NUM_BUF-1:0]        sel;
  logic [NUM_BUF-1:0]        wr;
  logic [NUM_BUF-1:0]        ack;
  logic [NUM_BUF-1:0]        full;
  logic [NUM_BUF-1:0][127:0] blk;

  assign sel = {s1, ~s1};
  assign ack = {key_ack, data_ack};

  // Ready looks only at the selected buffer's registered full flag, so an
  // ack in the same cycle cannot open the gate until the next cycle.
  assign in_ready = |(sel & ~full);
  assign wr       = {NUM_BUF{in_valid & in_ready}} & sel;

  for (genvar g = 0; g < NUM_BUF; g++) begin : g_buf
    byte_buf u_buf (
      .clk  (clk),
      .rst  (rst),
      .wr   (wr[g]),
      .din  (in_byte),
      .ack  (ack[g]),
      .blk  (blk[g]),
      .full (full[g])
    );
  end

  assign key_out   = blk[1];
  assign data_out  = blk[0];
  assign key_full  = full[1];
  assign data_full = full[0];
endmodule

// File: tb/tb_byte_demux_loader.sv
// Self-checking bench for byte_demux_loader: directed scenarios plus a
// randomized run, all checked against a byte-array reference model.
module tb_byte_demux_loader;
  logic         clk = 1'b0;
  logic         rst, s1, in_valid, in_ready, key_ack, data_ack;
  logic [7:0]   in_byte;
  logic [127:0] key_out, data_out;
  logic         key_full, data_full;

  byte_demux_loader dut (
    .clk(clk), .rst(rst), .s1(s1), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .key_ack(key_ack), .data_ack(data_ack),
    .key_out(key_out), .data_out(data_out),
    .key_full(key_full), .data_full(data_full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes stored by position, fill counts, full flags.
  logic [7:0] kb[16];
  logic [7:0] db[16];
  int         kc, dc;
  bit         kf, df;
  logic       rdy_obs, rdy_exp;

  function automatic logic [127:0] exp_key();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = kb[i];
    return v;
  endfunction

  function automatic logic [127:0] exp_data();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = db[i];
    return v;
  endfunction

  // Drive one cycle, capture in_ready before the edge, advance the model.
  task automatic step(input logic r, input logic sv, input logic v,
                      input logic [7:0] b, input logic ka, input logic da);
    bit acc, ak, ad;
    @(negedge clk);
    rst = r; s1 = sv; in_valid = v; in_byte = b; key_ack = ka; data_ack = da;
    #1;
    rdy_obs = in_ready;
    rdy_exp = sv ? !kf : !df;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) begin kb[i] = 8'h00; db[i] = 8'h00; end
      kc = 0; dc = 0; kf = 0; df = 0;
    end else begin
      acc = v && (sv ? !kf : !df);
      ak  = ka && kf;
      ad  = da && df;
      if (acc && sv) begin
        kb[kc] = b; kc = (kc + 1) % 16;
        if (kc == 0) kf = 1;
      end
      if (acc && !sv) begin
        db[dc] = b; dc = (dc + 1) % 16;
        if (dc == 0) df = 1;
      end
      if (ak) kf = 0;
      if (ad) df = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 1, 8'h5A, 1, 1);
    n_tests++;
    if (key_out !== 128'h0 || data_out !== 128'h0) begin
      n_fail++; $display("FAIL reset_outs: key_out=%h data_out=%h want 0", key_out, data_out);
    end
    n_tests++;
    if (key_full !== 1'b0 || data_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_full: key_full=%b data_full=%b want 0", key_full, data_full);
    end
    step(0, 1, 0, 8'h00, 0, 0);
    n_tests++;
    if (rdy_obs !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_key: in_ready=%b want 1", rdy_obs);
    end
    step(0, 0, 0, 8'h00, 0, 0);
    n_tests++;
    if (rdy_obs !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_data: in_ready=%b want 1", rdy_obs);
    end
  endtask

  task automatic test_key_fill();
    step(1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 8'(i), 0, 0);
      n_tests++;
      if (key_full !== kf || key_out !== exp_key()) begin
        n_fail++; $display("FAIL key_fill_%0d: key_full=%b key_out=%h want %b %h",
                           i, key_full, key_out, kf, exp_key());
      end
    end
    n_tests++;
    if (key_full !== 1'b1 || key_out !== 128'h000102030405060708090a0b0c0d0e0f) begin
      n_fail++; $display("FAIL key_fill_final: key_full=%b key_out=%h", key_full, key_out);
    end
    n_tests++;
    if (data_full !== 1'b0 || data_out !== 128'h0) begin
      n_fail++; $display("FAIL key_fill_data: data_full=%b data_out=%h want 0 0", data_full, data_out);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 8'hAA, 0, 0);
      n_tests++;
      if (rdy_obs !== 1'b0 || key_out !== 128'h000102030405060708090a0b0c0d0e0f || key_full !== 1'b1) begin
        n_fail++; $display("FAIL stall_%0d: in_ready=%b key_full=%b key_out=%h", i, rdy_obs, key_full, key_out);
      end
    end
    step(0, 1, 1, 8'hAA, 1, 0);
    n_tests++;
    if (rdy_obs !== 1'b0 || key_full !== 1'b0) begin
      n_fail++; $display("FAIL stall_ack: in_ready=%b key_full=%b want 0 0", rdy_obs, key_full);
    end
    step(0, 1, 1, 8'hAA, 0, 0);
    n_tests++;
    if (rdy_obs !== 1'b1 || key_out !== 128'haa0102030405060708090a0b0c0d0e0f) begin
      n_fail++; $display("FAIL stall_resume: in_ready=%b key_out=%h", rdy_obs, key_out);
    end
  endtask

  task automatic test_interleave();
    step(1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 8'(8'h10 + i), 0, 0);
      step(0, 0, 1, 8'(8'h20 + i), 0, 0);
    end
    n_tests++;
    if (key_full !== 1'b1 || data_full !== 1'b1) begin
      n_fail++; $display("FAIL interleave_full: key_full=%b data_full=%b want 1 1", key_full, data_full);
    end
    n_tests++;
    if (key_out !== 128'h101112131415161718191a1b1c1d1e1f || data_out !== 128'h202122232425262728292a2b2c2d2e2f) begin
      n_fail++; $display("FAIL interleave_data: key_out=%h data_out=%h", key_out, data_out);
    end
  endtask

  task automatic test_concurrent();
    step(0, 1, 0, 8'h00, 1, 0);            // free the key buffer
    step(0, 1, 1, 8'h55, 0, 1);            // data ack + key byte together
    n_tests++;
    if (rdy_obs !== 1'b1 || data_full !== 1'b0 || key_out[127:120] !== 8'h55) begin
      n_fail++; $display("FAIL concurrent: in_ready=%b data_full=%b key_byte0=%h want 1 0 55",
                         rdy_obs, data_full, key_out[127:120]);
    end
    step(0, 1, 1, 8'h66, 0, 0);
    n_tests++;
    if (key_out[119:112] !== 8'h66 || data_out !== 128'h202122232425262728292a2b2c2d2e2f) begin
      n_fail++; $display("FAIL concurrent_next: key_byte1=%h data_out=%h", key_out[119:112], data_out);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 8'($urandom), 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    n_tests++;
    if (data_out !== 128'h0 || data_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: data_out=%h data_full=%b want 0 0", data_out, data_full);
    end
    for (int i = 0; i < 16; i++) step(0, 0, 1, 8'(8'hF0 + i), 0, 0);
    n_tests++;
    if (data_out !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff || data_full !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_refill: data_out=%h data_full=%b", data_out, data_full);
    end
  endtask

  task automatic test_spurious_ack();
    step(1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'($urandom), 0, 0);
    step(0, 1, 0, 8'h00, 1, 0);
    n_tests++;
    if (key_full !== 1'b0 || key_out !== exp_key()) begin
      n_fail++; $display("FAIL spurious_ack: key_full=%b key_out=%h want 0 %h", key_full, key_out, exp_key());
    end
    for (int i = 0; i < 13; i++) step(0, 1, 1, 8'($urandom), 0, 0);
    n_tests++;
    if (key_full !== 1'b1 || key_out !== exp_key()) begin
      n_fail++; $display("FAIL spurious_complete: key_full=%b key_out=%h want 1 %h", key_full, key_out, exp_key());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
           8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      n_tests++;
      if (rdy_obs !== rdy_exp || key_full !== kf || data_full !== df ||
          key_out !== exp_key() || data_out !== exp_data()) begin
        n_fail++; $display("FAIL random_%0d: rdy=%b/%b kf=%b/%b df=%b/%b key=%h/%h data=%h/%h",
                           i, rdy_obs, rdy_exp, key_full, kf, data_full, df,
                           key_out, exp_key(), data_out, exp_data());
      end
    end
  endtask

  initial begin
    rst = 1'b1; s1 = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    key_ack = 1'b0; data_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin kb[i] = 8'h00; db[i] = 8'h00; end
    kc = 0; dc = 0; kf = 0; df = 0;
    test_reset();
    test_key_fill();
    test_stall();
    test_interleave();
    test_concurrent();
    test_reset_mid();
    test_spurious_ack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
